decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
Pipelined successor to the single-cycle control decoder: decodes RV32I control in the ID stage and registers the control bundle into an ID/EX register. It also detects load-use hazards (stall plus bubble) and resolves all six conditional branches and JAL/JALR in the EX stage (pc-select plus flush). It sits between the IF/ID register and the EX-stage ALU and drives PC select, pipeline freeze and flush.

Parameters:
ALUCTRL_W, 4, width of ALU operation code
RADDR_W, 5, register address width
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instr_i  in  32  instruction from IF/ID register
instr_valid_i  in  1  instr_i holds a real instruction
ex_eq_i  in  1  ALU flag, rs1==rs2, for instruction currently in EX
ex_lt_i  in  1  ALU flag, signed rs1<rs2
ex_ltu_i  in  1  ALU flag, unsigned rs1<rs2
ex_valid_o  out  1  EX-stage slot holds a real instruction
ex_reg_write_o  out  1  write rd
ex_alu_ctrl_o  out  ALUCTRL_W  ALU op
ex_alu_src_o  out  1  ALU B = immediate
ex_alu_a_pc_o  out  1  ALU A = PC (AUIPC)
ex_imm_src_o  out  3  immediate format
ex_result_src_o  out  2  writeback select
ex_mem_write_o  out  1  store
ex_mem_read_o  out  1  load
ex_rd_o  out  RADDR_W  destination register
stall_o  out  1  freeze PC and IF/ID this cycle
pc_src_o  out  1  redirect PC to branch/jump target
pc_jalr_o  out  1  target = ALU result (JALR), else PC+imm
flush_o  out  1  squash IF/ID and ID/EX
illegal_o  out  1  one-cycle pulse, unsupported opcode/funct3 decoded
stall_cnt_o  out  CNT_W  count of stall cycles, saturating

Behaviour:
- Reset (async, rst=1): all ex_* outputs 0, ex_valid_o 0, internal branch/jump type 0, stall_cnt_o 0. stall_o, pc_src_o and flush_o are then 0 because they derive from registers.
- Decode is combinational in ID. Control appears on ex_* one clk edge after instr_i is presented with instr_valid_i=1, stall_o=0 and flush_o=0.
- Supported opcodes: LOAD, STORE, OP, OP-IMM, LUI, AUIPC, BRANCH, JAL, JALR.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10.
- SUB only when opcode is OP and instr[30]=1. SRA when funct3=101 and instr[30]=1. Branches use SUB. Loads, stores, AUIPC and JAL/JALR use ADD. LUI uses PASSB.
- imm_src: I=0, S=1, B=2, J=3, U=4.
- result_src: ALU=0, MEM=1, PC+4=2 (JAL/JALR).
- reg_write is 0 for STORE/BRANCH, 1 otherwise. rd is 0 when reg_write=0.
- Illegal cases: unknown opcode; BRANCH funct3 010/011; LOAD/STORE funct3 other than 000/001/010/100/101 (load) or 000/001/010 (store).
- On an illegal case: illegal_o=1 for that cycle (only if instr_valid_i and not flushed), and a bubble is inserted.
- Load-use hazard: stall_o = ex_valid_o & ex_mem_read_o & ex_rd_o≠0 & instr_valid_i & (rs1 used & rs1==ex_rd_o | rs2 used & rs2==ex_rd_o).
  - rs1 is used by all except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH.
- EX resolution (combinational from registered type + flags):
  - taken = BEQ eq | BNE !eq | BLT lt | BGE !lt | BLTU ltu | BGEU !ltu.
  - pc_src_o = ex_valid_o & (jal | jalr | branch & taken).
  - pc_jalr_o = ex_valid_o & jalr.
  - flush_o = pc_src_o.
- ID/EX update each edge, in priority order:
  - flush_o: bubble (ex_valid 0, all controls 0).
  - else stall_o: bubble.
  - else: the decoded instruction, or a bubble if !instr_valid_i or illegal.
- Bubble: every write/memory enable 0, rd 0.
- flush_o and stall_o together: flush wins, and stall_o is forced to 0 when flush_o=1.
- stall_cnt_o increments on each edge where stall_o=1 and holds at all-ones.
- A stall lasts exactly one cycle. The bubble clears ex_mem_read_o, so the held instruction issues next cycle.
- Reset asserted mid-stall or mid-branch: everything clears immediately. The first instruction after release decodes normally.

Decomposition:
- Package decode_pkg: opcode constants; alu_op_e, imm_src_e, result_src_e, br_type_e enums; ctrl_t packed struct for the ID/EX bundle; BUBBLE constant.
- One sub-module, decode_comb: pure combinational instr to ctrl_t + illegal + rs-used flags.
- Top module holds the ID/EX register, hazard logic, branch resolution and counter.

Test Plan:
- Reset mid-run: assert rst during a stall → all outputs 0 the same cycle, stall_cnt_o=0.
- Load-use, then flush priority:
  - lw x5,0(x1) followed by add x6,x5,x2 → stall_o=1 one cycle, ex_valid_o=0 next, add issues the cycle after with ex_alu_ctrl_o=0, stall_cnt_o=1.
  - lw x0 then add x6,x0,x2 → no stall.
- bne x1,x2 in EX with ex_eq_i=0 → pc_src_o=1, flush_o=1. Next ID/EX is a bubble even if instr_i was a stall-causing add.
- Branch conditions: blt/bge/bltu/bgeu with lt=1, ltu=0 → taken=1,0,0,1 respectively.
  - jalr x1,0(x3) → pc_src_o=1, pc_jalr_o=1, result_src=2, rd=1.
- Illegal: instr 0x0000207F → illegal_o pulse, bubble.
- Saturation: force CNT_W=2 and run 5 stalls → stall_cnt_o=3.
- Width check: sub x3,x1,x2 (0x402081B3) → ALU 1, reg_write 1, alu_src 0. srai → ALU 7, alu_src 1.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the pipelined RV32I control decoder:
//   - major opcode constants
//   - ALU / immediate / result-select / branch-type encodings
//   - ctrl_t : the control bundle carried in the ID/EX register
//   - BUBBLE : the all-zero "no instruction" bundle
//   - helpers: funct3 -> ALU op mapping and EX-stage branch condition
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        alu_a_pc;
    imm_src_e    imm_src;
    result_src_e result_src;
    logic        mem_write;
    logic        mem_read;
    logic [4:0]  rd;
    br_type_e    br_type;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    valid:      1'b0,
    reg_write:  1'b0,
    alu_op:     ALU_ADD,
    alu_src:    1'b0,
    alu_a_pc:   1'b0,
    imm_src:    IMM_I,
    result_src: RES_ALU,
    mem_write:  1'b0,
    mem_read:   1'b0,
    rd:         5'd0,
    br_type:    BR_NONE
  };

  // Shared OP / OP-IMM funct3 mapping. SUB exists only for register-register
  // ops; for OP-IMM instr[30] is part of the immediate except on shifts.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                          input logic       alt,
                                          input logic       is_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Conditional-branch outcome from the EX-stage comparison flags.
  // Jumps and non-branches return 0; they are handled separately.
  function automatic logic branch_taken(input br_type_e t,
                                        input logic     eq,
                                        input logic     lt,
                                        input logic     ltu);
    logic tk;
    case (t)
      BR_BEQ:  tk = eq;
      BR_BNE:  tk = ~eq;
      BR_BLT:  tk = lt;
      BR_BGE:  tk = ~lt;
      BR_BLTU: tk = ltu;
      BR_BGEU: tk = ~ltu;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/decode_ctrl_pipe_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Pure combinational RV32I control decode for the ID stage.
// Ports:
//   i_instr      in  32  instruction word
//   o_ctrl       out     decoded control bundle (valid always 1 here; the
//                        pipeline register decides whether it is used)
//   o_illegal    out  1  unsupported opcode / funct3
//   o_rs1_used   out  1  instruction reads rs1 (0 when illegal)
//   o_rs2_used   out  1  instruction reads rs2 (0 when illegal)
//   o_rs1        out  5  rs1 field
//   o_rs2        out  5  rs2 field
// -----------------------------------------------------------------------------
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_rs1_used,
  output logic        o_rs2_used,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic       w_alt;
  ctrl_t      w_ctrl;
  logic       w_illegal;
  logic       w_rs1_used_raw;
  logic       w_rs2_used_raw;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_f3          = i_instr[14:12];
  assign w_alt         = i_instr[30];
  assign w_unused_bits = ^{i_instr[31], i_instr[29:25]};

  // Opcode/funct3 decode into the control bundle and legality flag.
  always_comb begin
    w_ctrl         = BUBBLE;
    w_ctrl.valid   = 1'b1;
    w_illegal      = 1'b0;
    w_rs1_used_raw = 1'b0;
    w_rs2_used_raw = 1'b0;
    case (w_opcode)
      OPC_LOAD: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_MEM;
        w_ctrl.mem_read   = 1'b1;
        w_rs1_used_raw    = 1'b1;
        case (w_f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
          default:                                w_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.imm_src   = IMM_S;
        w_ctrl.mem_write = 1'b1;
        w_rs1_used_raw   = 1'b1;
        w_rs2_used_raw   = 1'b1;
        case (w_f3)
          3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
          default:                w_illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = alu_from_f3(w_f3, w_alt, 1'b1);
        w_rs1_used_raw   = 1'b1;
        w_rs2_used_raw   = 1'b1;
      end
      OPC_OP_IMM: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = alu_from_f3(w_f3, w_alt, 1'b0);
        w_ctrl.alu_src   = 1'b1;
        w_rs1_used_raw   = 1'b1;
      end
      OPC_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_PASSB;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.imm_src   = IMM_U;
      end
      OPC_AUIPC: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_a_pc  = 1'b1;
        w_ctrl.imm_src   = IMM_U;
      end
      OPC_BRANCH: begin
        w_ctrl.alu_op  = ALU_SUB;
        w_ctrl.imm_src = IMM_B;
        w_rs1_used_raw = 1'b1;
        w_rs2_used_raw = 1'b1;
        case (w_f3)
          3'b000:  w_ctrl.br_type = BR_BEQ;
          3'b001:  w_ctrl.br_type = BR_BNE;
          3'b100:  w_ctrl.br_type = BR_BLT;
          3'b101:  w_ctrl.br_type = BR_BGE;
          3'b110:  w_ctrl.br_type = BR_BLTU;
          3'b111:  w_ctrl.br_type = BR_BGEU;
          default: w_illegal      = 1'b1;
        endcase
      end
      OPC_JAL: begin
        // Target is PC+imm from the dedicated adder; ALU operands set to
        // PC/imm so the ALU result is also that target.
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.alu_a_pc   = 1'b1;
        w_ctrl.imm_src    = IMM_J;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.br_type    = BR_JAL;
      end
      OPC_JALR: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.result_src = RES_PC4;
        w_ctrl.br_type    = BR_JALR;
        w_rs1_used_raw    = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase

    if (w_ctrl.reg_write) begin
      w_ctrl.rd = i_instr[11:7];
    end else begin
      w_ctrl.rd = 5'd0;
    end
  end

  // An illegal word is discarded anyway, so it must never trigger a stall.
  assign o_ctrl     = w_ctrl;
  assign o_illegal  = w_illegal;
  assign o_rs1_used = w_rs1_used_raw & ~w_illegal;
  assign o_rs2_used = w_rs2_used_raw & ~w_illegal;
  assign o_rs1      = i_instr[19:15];
  assign o_rs2      = i_instr[24:20];

endmodule

// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
// ID-stage control decode with ID/EX pipeline register, load-use hazard
// detection and EX-stage branch/jump resolution.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   instr_i             instruction from IF/ID
//   instr_valid_i       instr_i holds a real instruction
//   ex_eq_i/lt_i/ltu_i  ALU comparison flags for the instruction in EX
//   ex_*_o              registered control bundle for the EX stage
//   stall_o             freeze PC and IF/ID (load-use)
//   pc_src_o            redirect PC to branch/jump target
//   pc_jalr_o           target is the ALU result (JALR)
//   flush_o             squash IF/ID and ID/EX
//   illegal_o           unsupported instruction seen in ID this cycle
//   stall_cnt_o         saturating count of stall cycles
// -----------------------------------------------------------------------------
module decode_ctrl_pipe
  import decode_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int RADDR_W   = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr_i,
  input  logic                 instr_valid_i,
  input  logic                 ex_eq_i,
  input  logic                 ex_lt_i,
  input  logic                 ex_ltu_i,
  output logic                 ex_valid_o,
  output logic                 ex_reg_write_o,
  output logic [ALUCTRL_W-1:0] ex_alu_ctrl_o,
  output logic                 ex_alu_src_o,
  output logic                 ex_alu_a_pc_o,
  output logic [2:0]           ex_imm_src_o,
  output logic [1:0]           ex_result_src_o,
  output logic                 ex_mem_write_o,
  output logic                 ex_mem_read_o,
  output logic [RADDR_W-1:0]   ex_rd_o,
  output logic                 stall_o,
  output logic                 pc_src_o,
  output logic                 pc_jalr_o,
  output logic                 flush_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  ctrl_t            w_dec;
  logic             w_illegal;
  logic             w_rs1_used;
  logic             w_rs2_used;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;

  ctrl_t            r_ctrl;
  ctrl_t            w_ctrl_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_taken;
  logic             w_is_jump;
  logic             w_pc_src;
  logic             w_hazard;
  logic             w_stall;

  decode_comb u_decode_comb (
    .i_instr    (instr_i),
    .o_ctrl     (w_dec),
    .o_illegal  (w_illegal),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2)
  );

  // EX-stage resolution from the registered branch type and ALU flags.
  assign w_taken   = branch_taken(r_ctrl.br_type, ex_eq_i, ex_lt_i, ex_ltu_i);
  assign w_is_jump = (r_ctrl.br_type == BR_JAL) || (r_ctrl.br_type == BR_JALR);
  assign w_pc_src  = r_ctrl.valid & (w_is_jump | w_taken);

  // Load-use: a load in EX whose rd (non-zero) is read by the ID instruction.
  assign w_hazard = r_ctrl.valid & r_ctrl.mem_read & (r_ctrl.rd != 5'd0) &
                    instr_valid_i &
                    ((w_rs1_used & (w_rs1 == r_ctrl.rd)) |
                     (w_rs2_used & (w_rs2 == r_ctrl.rd)));

  // A redirect discards the ID instruction, so a stall would be meaningless.
  assign w_stall = w_hazard & ~w_pc_src;

  // Next ID/EX contents: flush, then stall, then the decoded instruction.
  always_comb begin
    w_ctrl_nxt = BUBBLE;
    if (w_pc_src) begin
      w_ctrl_nxt = BUBBLE;
    end else if (w_stall) begin
      w_ctrl_nxt = BUBBLE;
    end else if (!instr_valid_i || w_illegal) begin
      w_ctrl_nxt = BUBBLE;
    end else begin
      w_ctrl_nxt       = w_dec;
      w_ctrl_nxt.valid = 1'b1;
    end
  end

  // ID/EX control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= BUBBLE;
    end else begin
      r_ctrl <= w_ctrl_nxt;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign ex_valid_o      = r_ctrl.valid;
  assign ex_reg_write_o  = r_ctrl.reg_write;
  assign ex_alu_ctrl_o   = ALUCTRL_W'(r_ctrl.alu_op);
  assign ex_alu_src_o    = r_ctrl.alu_src;
  assign ex_alu_a_pc_o   = r_ctrl.alu_a_pc;
  assign ex_imm_src_o    = r_ctrl.imm_src;
  assign ex_result_src_o = r_ctrl.result_src;
  assign ex_mem_write_o  = r_ctrl.mem_write;
  assign ex_mem_read_o   = r_ctrl.mem_read;
  assign ex_rd_o         = RADDR_W'(r_ctrl.rd);

  assign stall_o     = w_stall;
  assign pc_src_o    = w_pc_src;
  assign pc_jalr_o   = r_ctrl.valid & (r_ctrl.br_type == BR_JALR);
  assign flush_o     = w_pc_src;
  assign illegal_o   = instr_valid_i & w_illegal & ~w_pc_src;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_pipe
// Directed scoreboard bench: stimulus pushes the expected EX bundle for every
// instruction that will issue; a negedge monitor pops and compares whenever
// ex_valid_o is high. Hazard/branch/illegal/counter outputs are checked inline.
// A second instance with CNT_W=2 shares the inputs to observe saturation.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        ex_eq_i, ex_lt_i, ex_ltu_i;

  logic        ex_valid_o, ex_reg_write_o, ex_alu_src_o, ex_alu_a_pc_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic [2:0]  ex_imm_src_o;
  logic [1:0]  ex_result_src_o;
  logic        ex_mem_write_o, ex_mem_read_o;
  logic [4:0]  ex_rd_o;
  logic        stall_o, pc_src_o, pc_jalr_o, flush_o, illegal_o;
  logic [15:0] stall_cnt_o;

  logic        d2_valid, d2_rw, d2_src, d2_apc, d2_mw, d2_mr;
  logic [3:0]  d2_alu;
  logic [2:0]  d2_imm;
  logic [1:0]  d2_res;
  logic [4:0]  d2_rd;
  logic        d2_stall, d2_pc_src, d2_jalr, d2_flush, d2_ill;
  logic [1:0]  d2_cnt;

  int n_pass  = 0;
  int n_total = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.ALUCTRL_W(4), .RADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .ex_eq_i(ex_eq_i), .ex_lt_i(ex_lt_i), .ex_ltu_i(ex_ltu_i),
    .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_alu_ctrl_o(ex_alu_ctrl_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_alu_a_pc_o(ex_alu_a_pc_o), .ex_imm_src_o(ex_imm_src_o),
    .ex_result_src_o(ex_result_src_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_rd_o(ex_rd_o), .stall_o(stall_o),
    .pc_src_o(pc_src_o), .pc_jalr_o(pc_jalr_o), .flush_o(flush_o),
    .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
  );

  decode_ctrl_pipe #(.ALUCTRL_W(4), .RADDR_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .ex_eq_i(ex_eq_i), .ex_lt_i(ex_lt_i), .ex_ltu_i(ex_ltu_i),
    .ex_valid_o(d2_valid), .ex_reg_write_o(d2_rw),
    .ex_alu_ctrl_o(d2_alu), .ex_alu_src_o(d2_src),
    .ex_alu_a_pc_o(d2_apc), .ex_imm_src_o(d2_imm),
    .ex_result_src_o(d2_res), .ex_mem_write_o(d2_mw),
    .ex_mem_read_o(d2_mr), .ex_rd_o(d2_rd), .stall_o(d2_stall),
    .pc_src_o(d2_pc_src), .pc_jalr_o(d2_jalr), .flush_o(d2_flush),
    .illegal_o(d2_ill), .stall_cnt_o(d2_cnt)
  );

  // Instruction words (hand-encoded)
  localparam logic [31:0] LW5    = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD652 = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] LW0    = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD602 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] BNE    = 32'h00209463; // bne  x1,x2,8
  localparam logic [31:0] JALR   = 32'h000180E7; // jalr x1,0(x3)
  localparam logic [31:0] ILL    = 32'h0000207F; // unknown opcode
  localparam logic [31:0] ILLBR  = 32'h0020A463; // branch funct3=010
  localparam logic [31:0] SUB    = 32'h402081B3; // sub  x3,x1,x2
  localparam logic [31:0] SRAI   = 32'h4030D213; // srai x4,x1,3
  localparam logic [31:0] LUI    = 32'h123453B7; // lui  x7,0x12345
  localparam logic [31:0] SW     = 32'h0020A223; // sw   x2,4(x1)

  // Expected bundle: {alu, reg_write, alu_src, alu_a_pc, imm, result, mem_write, mem_read, rd}
  function automatic logic [18:0] mk(input logic [3:0] alu, input logic rw,
                                     input logic src, input logic apc,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic mw, input logic mr,
                                     input logic [4:0] rd);
    return {alu, rw, src, apc, imm, res, mw, mr, rd};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic present(input logic [31:0] ins, input logic v);
    instr_i       = ins;
    instr_valid_i = v;
    @(negedge clk);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every issued instruction must match the queue head.
  always @(negedge clk) begin
    if (!rst && ex_valid_o) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL ex_unexpected: ex_valid_o=1 with nothing expected, alu=%0d rd=%0d",
                 ex_alu_ctrl_o, ex_rd_o);
      end else begin
        logic [18:0] e, a;
        e = exp_q.pop_front();
        a = {ex_alu_ctrl_o, ex_reg_write_o, ex_alu_src_o, ex_alu_a_pc_o, ex_imm_src_o,
             ex_result_src_o, ex_mem_write_o, ex_mem_read_o, ex_rd_o};
        if (a === e) n_pass++;
        else $display("FAIL ex_bundle: got %05h expected %05h", a, e);
      end
    end
  end

  logic [31:0] br_ins[5];
  logic [2:0]  br_flg[5]; // {eq, lt, ltu}
  logic        br_tk[5];

  initial begin
    br_ins[0] = 32'h00208463; br_flg[0] = 3'b100; br_tk[0] = 1'b1; // beq,  eq=1
    br_ins[1] = 32'h0020C463; br_flg[1] = 3'b010; br_tk[1] = 1'b1; // blt,  lt=1
    br_ins[2] = 32'h0020D463; br_flg[2] = 3'b010; br_tk[2] = 1'b0; // bge,  lt=1
    br_ins[3] = 32'h0020E463; br_flg[3] = 3'b010; br_tk[3] = 1'b0; // bltu, ltu=0
    br_ins[4] = 32'h0020F463; br_flg[4] = 3'b010; br_tk[4] = 1'b1; // bgeu, ltu=0

    rst = 1'b1; instr_i = 32'd0; instr_valid_i = 1'b0;
    ex_eq_i = 1'b0; ex_lt_i = 1'b0; ex_ltu_i = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_outputs", {ex_valid_o, ex_reg_write_o, ex_alu_ctrl_o, ex_alu_src_o,
        ex_alu_a_pc_o, ex_imm_src_o, ex_result_src_o, ex_mem_write_o, ex_mem_read_o,
        ex_rd_o, stall_o, pc_src_o, pc_jalr_o, flush_o}, 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    adv;
    rst = 1'b0;

    // Load-use: lw x5 ; add x6,x5,x2
    exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b1, 5'd5));
    present(LW5, 1'b1);  chk("lu_first_no_stall", stall_o, 32'd0); adv;
    present(ADD652, 1'b1); chk("lu_stall", stall_o, 32'd1); adv;
    exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd6));
    present(ADD652, 1'b1);
    chk("lu_bubble", ex_valid_o, 32'd0);
    chk("lu_stall_one_cycle", stall_o, 32'd0);
    adv;
    // lw x0 ; add x6,x0,x2 -> no stall
    exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b1, 5'd0));
    present(LW0, 1'b1); chk("lu_cnt_1", stall_cnt_o, 32'd1); adv;
    exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd6));
    present(ADD602, 1'b1); chk("lu_x0_no_stall", stall_o, 32'd0); adv;

    // bne taken flushes the following add
    exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 5'd0));
    present(BNE, 1'b1); adv;
    ex_eq_i = 1'b0;
    present(ADD652, 1'b1);
    chk("bne_pc_src", pc_src_o, 32'd1);
    chk("bne_flush", flush_o, 32'd1);
    chk("bne_not_jalr", pc_jalr_o, 32'd0);
    adv;
    present(32'd0, 1'b0); chk("flush_bubble", ex_valid_o, 32'd0); adv;

    // Illegal word in the flushed slot does not pulse illegal_o
    exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 5'd0));
    present(BNE, 1'b1); adv;
    present(ILL, 1'b1); chk("ill_masked_by_flush", illegal_o, 32'd0); adv;

    // Branch condition table
    for (int i = 0; i < 5; i++) begin
      ex_eq_i = 1'b0; ex_lt_i = 1'b0; ex_ltu_i = 1'b0;
      exp_q.push_back(mk(4'd1, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, 5'd0));
      present(br_ins[i], 1'b1); adv;
      {ex_eq_i, ex_lt_i, ex_ltu_i} = br_flg[i];
      present(32'd0, 1'b0);
      chk($sformatf("br_taken_%0d", i), pc_src_o, {31'd0, br_tk[i]});
      adv;
    end
    ex_eq_i = 1'b0; ex_lt_i = 1'b0; ex_ltu_i = 1'b0;

    // jalr x1,0(x3)
    exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, 5'd1));
    present(JALR, 1'b1); adv;
    present(32'd0, 1'b0);
    chk("jalr_pc_src", pc_src_o, 32'd1);
    chk("jalr_sel", pc_jalr_o, 32'd1);
    adv;

    // Illegal instructions
    present(ILL, 1'b1); chk("ill_pulse", illegal_o, 32'd1); adv;
    present(ILLBR, 1'b1);
    chk("ill_br_pulse", illegal_o, 32'd1);
    chk("ill_bubble", ex_valid_o, 32'd0);
    adv;
    present(32'd0, 1'b0);
    chk("ill_pulse_end", illegal_o, 32'd0);
    chk("ill_br_bubble", ex_valid_o, 32'd0);
    adv;

    // Field checks: sub, srai, lui, sw
    exp_q.push_back(mk(4'd1,  1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd3));
    present(SUB, 1'b1); adv;
    exp_q.push_back(mk(4'd7,  1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd4));
    present(SRAI, 1'b1); adv;
    exp_q.push_back(mk(4'd10, 1'b1, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, 5'd7));
    present(LUI, 1'b1); adv;
    exp_q.push_back(mk(4'd0,  1'b0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0, 5'd0));
    present(SW, 1'b1); adv;
    present(32'd0, 1'b0); adv;

    // Four more load-use stalls (five in total)
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b1, 5'd5));
      present(LW5, 1'b1); adv;
      present(ADD652, 1'b1); chk($sformatf("sat_stall_%0d", k), stall_o, 32'd1); adv;
      exp_q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd6));
      present(ADD652, 1'b1); adv;
    end
    present(32'd0, 1'b0);
    chk("cnt_5", stall_cnt_o, 32'd5);
    chk("cnt_sat_2bit", {30'd0, d2_cnt}, 32'd3);
    adv;

    // Reset asserted in the middle of a stall
    exp_q.push_back(mk(4'd0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b1, 5'd5));
    present(LW5, 1'b1); adv;
    present(ADD652, 1'b1); chk("pre_rst_stall", stall_o, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {ex_valid_o, ex_reg_write_o, ex_alu_ctrl_o, ex_alu_src_o,
        ex_alu_a_pc_o, ex_imm_src_o, ex_result_src_o, ex_mem_write_o, ex_mem_read_o,
        ex_rd_o, stall_o, pc_src_o, pc_jalr_o, flush_o}, 32'd0);
    chk("midrst_cnt", stall_cnt_o, 32'd0);
    chk("midrst_cnt_sat", {30'd0, d2_cnt}, 32'd0);
    adv;
    rst = 1'b0;
    exp_q.push_back(mk(4'd1, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 5'd3));
    present(SUB, 1'b1); chk("post_rst_no_stall", stall_o, 32'd0); adv;
    present(32'd0, 1'b0); adv;
    present(32'd0, 1'b0); adv;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
